// File: rtl/mem_port_arbiter.sv
// Two-port req/gnt/ack arbiter in front of a single-port synchronous memory, with IO word decode.
// Define MEM_PORT_ARBITER_ROUND_ROBIN_EN to break A/B ties by last owner instead of fixed A priority.
module mem_port_arbiter #(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] IO_ADDR = 'h00FF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    state_e            state_q;
    logic              owner_q;
    logic              we_q;
    logic              is_io_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              a_gnt_q;
    logic              b_gnt_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic [DATA_W-1:0] io_out_q;
    logic [DATA_W-1:0] io_sample_q;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    logic              last_owner_q;
`endif

    logic              pick_b_d;
    logic              sel_we_d;
    logic [ADDR_W-1:0] sel_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;
    logic              sel_is_io_d;

    // Winner selection is only consumed in IDLE; a lone requester always wins.
    always_comb begin
        pick_b_d = ~a_req;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        if (a_req && b_req) begin
            pick_b_d = (last_owner_q == OWNER_A);
        end
`endif
        sel_we_d    = pick_b_d ? b_we    : a_we;
        sel_addr_d  = pick_b_d ? b_addr  : a_addr;
        sel_wdata_d = pick_b_d ? b_wdata : a_wdata;
        sel_is_io_d = (sel_addr_d == IO_ADDR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWNER_A;
            we_q        <= 1'b0;
            is_io_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            io_out_q    <= '0;
            io_sample_q <= '0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
            last_owner_q <= OWNER_B;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (a_req || b_req) begin
                        owner_q     <= pick_b_d;
                        we_q        <= sel_we_d;
                        is_io_q     <= sel_is_io_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        // The IO word is handled locally and must never strobe the memory.
                        mem_we_q    <= sel_we_d & ~sel_is_io_d;
                        a_gnt_q     <= ~pick_b_d;
                        b_gnt_q     <= pick_b_d;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    a_gnt_q  <= 1'b0;
                    b_gnt_q  <= 1'b0;
                    mem_we_q <= 1'b0;
                    a_ack_q  <= (owner_q == OWNER_A);
                    b_ack_q  <= (owner_q == OWNER_B);
                    if (is_io_q) begin
                        if (we_q) begin
                            io_out_q <= mem_wdata_q;
                        end else begin
                            io_sample_q <= io_in;
                        end
                    end
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
                    last_owner_q <= owner_q;
`endif
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // mem_rdata only becomes valid in RESP, so the read mux stays combinational.
    always_comb begin
        rdata = '0;
        if ((state_q == ST_RESP) && !we_q) begin
            rdata = is_io_q ? io_sample_q : mem_rdata;
        end
    end

    assign a_gnt     = a_gnt_q;
    assign b_gnt     = b_gnt_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign io_out    = io_out_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus tie, reset and req-drop sequences.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_ack, b_gnt, b_ack;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata, io_in, io_out;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_ack     (a_ack),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_ack     (b_ack),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .io_in     (io_in),
        .io_out    (io_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memory model: data for mem_addr appears the cycle after it is presented.
    logic [15:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    end
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle exclusivity and idle-rdata checks.
    always @(negedge clock) begin
        if (reset) begin
            checks++;
            if ((a_gnt && b_gnt) || (a_ack && b_ack) || (!a_ack && !b_ack && rdata !== 16'h0000)) begin
                errors++;
                $display("FAIL exclusive: gnt=%b%b ack=%b%b rdata=%h", a_gnt, b_gnt, a_ack, b_ack, rdata);
            end
        end
    end

    typedef struct {
        logic        port_b;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] io_val;
        logic [15:0] exp_rdata;
        logic        exp_mem_we;
        logic [15:0] exp_io_out;
    } txn_t;

    txn_t vec [10];

    task automatic do_txn(input txn_t t, input int idx);
        @(negedge clock);
        io_in = t.io_val;
        if (t.port_b) begin
            b_req = 1'b1; b_we = t.we; b_addr = t.addr; b_wdata = t.wdata;
        end else begin
            a_req = 1'b1; a_we = t.we; a_addr = t.addr; a_wdata = t.wdata;
        end
        @(negedge clock);
        chk($sformatf("v%0d_gnt_owner", idx), {15'd0, t.port_b ? b_gnt : a_gnt}, 16'd1);
        chk($sformatf("v%0d_gnt_other", idx), {15'd0, t.port_b ? a_gnt : b_gnt}, 16'd0);
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, t.addr);
        chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, t.wdata);
        chk($sformatf("v%0d_mem_we", idx), {15'd0, mem_we}, {15'd0, t.exp_mem_we});
        @(negedge clock);
        chk($sformatf("v%0d_ack", idx), {15'd0, t.port_b ? b_ack : a_ack}, 16'd1);
        chk($sformatf("v%0d_gnt_off", idx), {15'd0, a_gnt | b_gnt | mem_we}, 16'd0);
        chk($sformatf("v%0d_rdata", idx), rdata, t.exp_rdata);
        chk($sformatf("v%0d_io_out", idx), io_out, t.exp_io_out);
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clock);
        chk($sformatf("v%0d_idle", idx), {14'd0, a_ack | b_ack, a_gnt | b_gnt}, 16'd0);
    endtask

    initial begin
        reset = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        io_in = 16'h0000;

        //         port  we    addr      wdata     io_in     rdata     mem_we io_out
        vec[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 1'b1, 16'h0000};
        vec[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 16'h0000};
        vec[2] = '{1'b1, 1'b1, 16'h00FF, 16'h1234, 16'h0000, 16'h0000, 1'b0, 16'h1234};
        vec[3] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0, 16'h1234};
        vec[4] = '{1'b1, 1'b1, 16'h0020, 16'hCAFE, 16'h0000, 16'h0000, 1'b1, 16'h1234};
        vec[5] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 16'hCAFE, 1'b0, 16'h1234};
        vec[6] = '{1'b0, 1'b0, 16'h00FF, 16'h9999, 16'h0F0F, 16'h0F0F, 1'b0, 16'h1234};
        vec[7] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 16'h1234};
        vec[8] = '{1'b0, 1'b1, 16'h00FF, 16'h00A5, 16'h0000, 16'h0000, 1'b0, 16'h00A5};
        vec[9] = '{1'b1, 1'b1, 16'h0000, 16'h7777, 16'h0000, 16'h0000, 1'b1, 16'h00A5};

        repeat (2) @(negedge clock);
        chk("rst_gnt_ack", {12'd0, a_gnt, b_gnt, a_ack, b_ack}, 16'd0);
        chk("rst_mem_we", {15'd0, mem_we}, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_io_out", io_out, 16'h0000);
        chk("rst_rdata", rdata, 16'h0000);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            do_txn(vec[i], i);
        end

        // Tie with both held: A first (fixed priority, or RR after last owner B), B once A drops.
        @(negedge clock);
        a_req = 1; a_we = 0; a_addr = 16'h0010;
        b_req = 1; b_we = 0; b_addr = 16'h0020;
        @(negedge clock);
        chk("tie_first_a_gnt", {14'd0, a_gnt, b_gnt}, 16'b10);
        @(negedge clock);
        chk("tie_first_a_ack", {14'd0, a_ack, b_ack}, 16'b10);
        chk("tie_first_rdata", rdata, 16'hBEEF);
        a_req = 0;
        @(negedge clock);
        chk("tie_idle", {14'd0, a_gnt, b_gnt}, 16'b00);
        @(negedge clock);
        chk("tie_then_b_gnt", {14'd0, a_gnt, b_gnt}, 16'b01);
        @(negedge clock);
        chk("tie_then_b_ack", {14'd0, a_ack, b_ack}, 16'b01);
        chk("tie_then_b_rdata", rdata, 16'hCAFE);
        b_req = 0;
        @(negedge clock);

        // Both continuously re-requesting; last owner is B at this point.
        @(negedge clock);
        a_req = 1;
        b_req = 1;
        for (int k = 0; k < 4; k++) begin
            logic exp_b;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
            exp_b = (k % 2) == 1;
`else
            exp_b = 1'b0;
`endif
            @(negedge clock);
            chk($sformatf("rr%0d_gnt", k), {14'd0, a_gnt, b_gnt}, exp_b ? 16'b01 : 16'b10);
            @(negedge clock);
            chk($sformatf("rr%0d_ack", k), {14'd0, a_ack, b_ack}, exp_b ? 16'b01 : 16'b10);
            chk($sformatf("rr%0d_rdata", k), rdata, exp_b ? 16'hCAFE : 16'hBEEF);
            @(negedge clock);
        end
        a_req = 0;
        b_req = 0;
        @(negedge clock);

        // Reset asserted during ACCESS of a write aborts it with no ack and no memory write.
        @(negedge clock);
        a_req = 1; a_we = 1; a_addr = 16'h0030; a_wdata = 16'h1111;
        @(negedge clock);
        chk("abort_pre_gnt", {14'd0, a_gnt, mem_we}, 16'b11);
        #2;
        reset = 1'b0;
        a_req = 0;
        #1;
        chk("abort_mem_we", {15'd0, mem_we}, 16'd0);
        chk("abort_gnt_ack", {12'd0, a_gnt, b_gnt, a_ack, b_ack}, 16'd0);
        chk("abort_io_out", io_out, 16'h0000);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk($sformatf("abort_no_ack%0d", k), {12'd0, a_gnt, b_gnt, a_ack, b_ack}, 16'd0);
        end
        do_txn('{1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000}, 10);

        // Dropping req during ACCESS still completes the access.
        @(negedge clock);
        a_req = 1; a_we = 0; a_addr = 16'h0010;
        @(negedge clock);
        chk("drop_gnt", {14'd0, a_gnt, b_gnt}, 16'b10);
        a_req = 0;
        @(negedge clock);
        chk("drop_ack", {14'd0, a_ack, b_ack}, 16'b10);
        chk("drop_rdata", rdata, 16'hBEEF);
        @(negedge clock);
        chk("drop_idle", {12'd0, a_gnt, b_gnt, a_ack, b_ack}, 16'd0);
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit memory in the memory datapath between two requesters: port A (CPU data/fetch path) and port B (IO/DMA engine).
- Serialises accesses with a registered req/gnt/ack handshake.
- Decodes the memory-mapped IO word so IO accesses never reach memory and IO reads return the sampled input pin value.
- Sits between the PC/SP/memory block and the memory array, replacing the combinational IO-address check.

Parameters:
DATA_W, 16, data width of every data bus
ADDR_W, 16, address width of every address bus
IO_ADDR, 16'h00FF, word address decoded as the memory-mapped IO register

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
a_req  in  1  port A request; held high until a_ack
a_we  in  1  port A write enable (1 = write)
a_addr  in  ADDR_W  port A address
a_wdata  in  DATA_W  port A write data
a_gnt  out  1  port A access in progress (ACCESS state)
a_ack  out  1  port A completion, one-cycle pulse
b_req, b_we, b_addr, b_wdata, b_gnt, b_ack  same as port A, for port B
rdata  out  DATA_W  read data, valid while a_ack or b_ack is high
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_we  out  1  memory write strobe, registered
mem_rdata  in  DATA_W  memory read data, synchronous (valid the cycle after mem_addr is presented)
io_in  in  DATA_W  external IO input
io_out  out  DATA_W  IO output register

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - a_gnt, b_gnt, a_ack, b_ack, mem_we = 0.
  - mem_addr, mem_wdata, io_out = 0.
  - last_owner=B.
  - Reset mid-transaction aborts it: no ack is issued, and mem_we drops immediately.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3 cycles per access, one access in flight at a time.
- IDLE:
  - If any req is high, select an owner, latch its we/addr/wdata, go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS (1 cycle):
  - Owner's gnt=1.
  - mem_addr and mem_wdata driven from the latched values.
  - mem_we = latched_we AND (latched_addr != IO_ADDR).
  - If latched_addr == IO_ADDR and latched_we=1: io_out <= latched_wdata at the end of this cycle.
  - If latched_addr == IO_ADDR and latched_we=0: io_in is registered into io_sample.
- RESP (1 cycle):
  - Owner's ack=1. gnt=0. mem_we=0.
  - rdata = io_sample if the latched address was IO_ADDR, else mem_rdata.
  - For writes, rdata = 0.
  - Update last_owner, then go to IDLE.
- Latency: a req sampled in IDLE at cycle N gives gnt at N+1 and ack at N+2. The earliest next grant is at N+4, because IDLE takes 1 cycle.
- Requester protocol:
  - Inputs are sampled only in IDLE. Changes during ACCESS/RESP are ignored.
  - Dropping req after selection does not cancel the access; the ack is still issued.
  - The requester must drop req the cycle after it sees ack. Otherwise it is re-arbitrated as a new request.
- Arbitration (default, fixed priority): A wins when both requests are high. B can starve if A is continuously busy; this is accepted.
- Only one gnt and one ack are ever high at a time. rdata = 0 whenever no ack is high.
- io_out holds its value until the next IO write or reset.

Optional Feature:
- Macro: MEM_PORT_ARBITER_ROUND_ROBIN_EN.
- Defined: when both req are high in IDLE, the port that is not last_owner wins. After reset (last_owner=B), A wins the first tie. A lone requester always wins.
- Undefined: fixed priority to A; last_owner is unused and may be optimised away.

Test Plan:
- Reset release, a_req=1, a_we=1, a_addr=16'h0010, a_wdata=16'hBEEF:
  - a_gnt at N+1 with mem_we=1, mem_addr=16'h0010, mem_wdata=16'hBEEF.
  - a_ack at N+2.
- Then A reads 16'h0010 (memory model returns 16'hBEEF):
  - a_ack at N+2 with rdata=16'hBEEF.
  - mem_we=0 throughout.
- B writes 16'h1234 to 16'h00FF:
  - mem_we stays 0.
  - io_out=16'h1234 after ACCESS; b_ack pulses.
  - Next, io_in=16'h5A5A and B reads 16'h00FF: rdata=16'h5A5A at b_ack.
- a_req and b_req both high, held:
  - Default build: A is served first, then B once a_req drops.
  - With MEM_PORT_ARBITER_ROUND_ROBIN_EN and both continuously re-requesting: grants alternate A, B, A, B.
- Assert reset=0 while in ACCESS of a write:
  - mem_we, gnt and ack go to 0 immediately.
  - No ack is issued; state=IDLE after release.
- Drop a_req during ACCESS:
  - a_ack still pulses at RESP.
  - Checker confirms gnt/ack are never both high on A and B in any cycle.
